// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key expansion sequencer: loads four key columns, expands them
// to 4*(NR+1) round-key words (one per cycle) and serves them to AddRoundKey.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   key_start, key_word   : key load pulse and streamed key columns
//   key_busy              : high while loading or expanding
//   key_expand_done       : level, high once every word is stored
//   sbox_req              : controller owns the shared S-box this cycle
//   sbox_word_out         : RotWord(w[i-1]) to SubWord, 0 when idle
//   sbox_word_in          : SubWord result (combinational)
//   rk_round, rk_col      : round-key read address
//   rk_word               : w[4*rk_round+rk_col], 0 past the last round
//   dbg_state             : FSM state encoding
//   dbg_word_idx          : current write index i
module aes_key_schedule_ctrl #(
    parameter int NR     = 10,
    parameter int WIDX_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_start,
    input  logic [31:0]       key_word,
    output logic              key_busy,
    output logic              key_expand_done,
    output logic              sbox_req,
    output logic [31:0]       sbox_word_out,
    input  logic [31:0]       sbox_word_in,
    input  logic [3:0]        rk_round,
    input  logic [1:0]        rk_col,
    output logic [31:0]       rk_word,
    output logic [1:0]        dbg_state,
    output logic [WIDX_W-1:0] dbg_word_idx
);

    localparam int NW = 4 * (NR + 1);
    localparam logic [WIDX_W-1:0] LP_LAST = WIDX_W'(NW - 1);
    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WIDX_W-1:0] r_idx;
    logic [WIDX_W-1:0] w_idx_nxt;
    logic [WIDX_W-1:0] w_waddr;
    logic [WIDX_W-1:0] w_rk_idx;
    logic [31:0]       r_w [NW];
    logic              w_we;
    logic [31:0]       w_wdata;
    logic [31:0]       w_prev;
    logic [31:0]       w_back4;
    logic [31:0]       w_rot;
    logic [31:0]       w_temp;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] v;
        case (n)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Taps into the store for the recurrence w[i] = w[i-4] ^ temp
    assign w_prev  = r_w[r_idx - WIDX_W'(1)];
    assign w_back4 = r_w[r_idx - WIDX_W'(4)];
    assign w_rot   = {w_prev[23:0], w_prev[31:24]};

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_we            = 1'b0;
        w_waddr         = r_idx;
        w_wdata         = key_word;
        w_temp          = w_prev;
        sbox_req        = 1'b0;
        sbox_word_out   = 32'h0;
        key_busy        = 1'b0;
        key_expand_done = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                key_expand_done = (r_state == S_DONE);
                // A new key restarts from column 0 even after a finished run
                if (key_start) begin
                    w_we        = 1'b1;
                    w_waddr     = '0;
                    w_idx_nxt   = WIDX_W'(1);
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                key_busy  = 1'b1;
                w_we      = 1'b1;
                w_idx_nxt = r_idx + WIDX_W'(1);
                if (r_idx == WIDX_W'(3)) begin
                    w_state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                key_busy = 1'b1;
                if (r_idx[1:0] == 2'b00) begin
                    sbox_req      = 1'b1;
                    sbox_word_out = w_rot;
                    w_temp        = sbox_word_in
                                  ^ {rcon(4'(r_idx >> 2)), 24'h0};
                end
                w_we      = 1'b1;
                w_wdata   = w_back4 ^ w_temp;
                w_idx_nxt = r_idx + WIDX_W'(1);
                if (r_idx == LP_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NW; k++) begin
                r_w[k] <= 32'h0;
            end
        end else if (w_we) begin
            r_w[w_waddr] <= w_wdata;
        end
    end

    // {round, col} is exactly 4*round+col
    assign w_rk_idx = WIDX_W'({rk_round, rk_col});
    assign rk_word  = (rk_round > LP_NR) ? 32'h0 : r_w[w_rk_idx];

    assign dbg_state    = r_state;
    assign dbg_word_idx = r_idx;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Scoreboard bench for aes_key_schedule_ctrl with a reference SubWord model.
// Stimulus queues expected events; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_aes_key_schedule_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_start = 1'b0;
    logic [31:0] key_word = 32'h0;
    logic        key_busy;
    logic        key_expand_done;
    logic        sbox_req;
    logic [31:0] sbox_word_out;
    logic [31:0] sbox_word_in;
    logic [3:0]  rk_round = 4'd0;
    logic [1:0]  rk_col = 2'd0;
    logic [31:0] rk_word;
    logic [1:0]  dbg_state;
    logic [5:0]  dbg_word_idx;

    always #100 clock = ~clock;

    aes_key_schedule_ctrl #(.NR(10), .WIDX_W(6)) dut (
        .clock           (clock),
        .reset           (reset),
        .key_start       (key_start),
        .key_word        (key_word),
        .key_busy        (key_busy),
        .key_expand_done (key_expand_done),
        .sbox_req        (sbox_req),
        .sbox_word_out   (sbox_word_out),
        .sbox_word_in    (sbox_word_in),
        .rk_round        (rk_round),
        .rk_col          (rk_col),
        .rk_word         (rk_word),
        .dbg_state       (dbg_state),
        .dbg_word_idx    (dbg_word_idx)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h0;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box = affine(x^254) in GF(2^8)
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 7; k >= 0; k--) begin
            r = gmul(r, r);
            if (k != 0) r = gmul(r, a);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign sbox_word_in = {sb(sbox_word_out[31:24]), sb(sbox_word_out[23:16]),
                           sb(sbox_word_out[15:8]),  sb(sbox_word_out[7:0])};

    typedef enum logic [1:0] {EV_RESET, EV_DONE, EV_DROP} ev_e;
    typedef struct {
        ev_e               kind;
        int                cyc;
        logic [11:0][31:0] w;
    } ev_t;

    ev_t ev_q[$];
    int  sb_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  rst_q = 1'b1;
    bit  fin = 1'b0;

    // words 0..3 = round 0, 4..7 = round 1, 8..11 = round 10
    logic [31:0] fips_w [12] = '{
        32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
        32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605,
        32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
    logic [31:0] zero_w [12] = '{
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363,
        32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e};

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        ev_t  e;
        ev_e  kind;
        bit   hit;
        bit   done_q;
        bit   d;
        done_q = 1'b0;
        forever begin
            @(negedge clock);
            if (fin) begin
                chk("ev_queue_drained", 32'(ev_q.size()), 32'd0);
                chk("sbox_queue_drained", 32'(sb_q.size()), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures",
                         n_chk, n_fail);
                $finish;
            end
            if (sbox_req) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sbox_unexpected cycle %0d: got req=1 expected req=0", cyc);
                end else begin
                    chk("sbox_cycle", 32'(cyc), 32'(sb_q.pop_front()));
                end
            end else begin
                chk("sbox_idle_word", sbox_word_out, 32'h0);
            end
            d   = key_expand_done;
            hit = 1'b1;
            kind = EV_RESET;
            if (rst_q && !reset) kind = EV_RESET;
            else if (d && !done_q) kind = EV_DONE;
            else if (!d && done_q) kind = EV_DROP;
            else hit = 1'b0;
            done_q = d;
            if (hit) begin
                if (ev_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL event_unexpected cycle %0d: got kind %0d expected none",
                             cyc, kind);
                end else begin
                    e = ev_q.pop_front();
                    chk("event_kind", 32'(kind), 32'(e.kind));
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    case (kind)
                        EV_RESET: begin
                            chk("rst_busy", 32'(key_busy), 32'd0);
                            chk("rst_done", 32'(d), 32'd0);
                            chk("rst_sbox_req", 32'(sbox_req), 32'd0);
                            chk("rst_state", 32'(dbg_state), 32'd0);
                            chk("rst_idx", 32'(dbg_word_idx), 32'd0);
                            for (int r = 0; r < 16; r++) begin
                                for (int c = 0; c < 4; c++) begin
                                    rk_round = 4'(r);
                                    rk_col   = 2'(c);
                                    #1;
                                    chk("rst_rk_zero", rk_word, 32'h0);
                                end
                            end
                        end
                        EV_DONE: begin
                            chk("done_busy", 32'(key_busy), 32'd0);
                            chk("done_state", 32'(dbg_state), 32'd3);
                            chk("done_idx", 32'(dbg_word_idx), 32'd44);
                            for (int j = 0; j < 12; j++) begin
                                rk_round = (j < 4) ? 4'd0 : (j < 8) ? 4'd1 : 4'd10;
                                rk_col   = 2'(j % 4);
                                #1;
                                chk("done_rk", rk_word, e.w[j]);
                            end
                            for (int r = 11; r < 16; r++) begin
                                for (int c = 0; c < 4; c++) begin
                                    rk_round = 4'(r);
                                    rk_col   = 2'(c);
                                    #1;
                                    chk("rk_out_of_range", rk_word, 32'h0);
                                end
                            end
                        end
                        default: begin
                            chk("drop_busy", 32'(key_busy), 32'd1);
                            chk("drop_state", 32'(dbg_state), 32'd1);
                        end
                    endcase
                    rk_round = 4'd0;
                    rk_col   = 2'd0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called in cycle T: drives the four columns and queues expectations
    task automatic drive_key(input logic [31:0] xw [12], input bit from_done,
                             input int abort_at, output int t);
        ev_t e;
        t = cyc;
        e.w = '0;
        if (from_done) begin
            e.kind = EV_DROP;
            e.cyc  = t + 1;
            ev_q.push_back(e);
        end
        for (int j = 1; j <= 10; j++) begin
            if (abort_at == 0 || 4 * j <= abort_at) sb_q.push_back(t + 4 * j);
        end
        if (abort_at == 0) begin
            e.kind = EV_DONE;
            e.cyc  = t + 44;
            for (int j = 0; j < 12; j++) e.w[j] = xw[j];
            ev_q.push_back(e);
        end
        key_start = 1'b1;
        key_word  = xw[0];
        for (int k = 1; k < 4; k++) begin
            tick();
            key_start = 1'b0;
            key_word  = xw[k];
        end
        tick();
        key_word = 32'hdeadbeef;
    endtask

    task automatic run_to(input int t_end, input int s1, input int s2);
        while (cyc < t_end) begin
            tick();
            key_start = (cyc == s1) || (cyc == s2);
            key_word  = $urandom;
        end
        key_start = 1'b0;
    endtask

    initial begin : stimulus
        ev_t e;
        int  t;
        e.w = '0;
        repeat (3) tick();
        e.kind = EV_RESET;
        e.cyc  = cyc;
        ev_q.push_back(e);
        reset = 1'b0;
        repeat (2) tick();

        drive_key(fips_w, 1'b0, 0, t);
        run_to(t + 50, t + 10, t + 30);

        tick();
        drive_key(zero_w, 1'b1, 0, t);
        run_to(t + 50, -1, -1);

        tick();
        drive_key(fips_w, 1'b1, 20, t);
        run_to(t + 20, -1, -1);
        reset = 1'b1;
        tick();
        e.kind = EV_RESET;
        e.cyc  = cyc;
        ev_q.push_back(e);
        reset = 1'b0;
        repeat (3) tick();

        drive_key(fips_w, 1'b0, 0, t);
        run_to(t + 50, -1, -1);

        repeat (3) tick();
        fin = 1'b1;
    end

    initial begin : watchdog
        #(200 * 3000);
        $display("FAIL watchdog: got no finish expected finish within 3000 cycles");
        $fatal(1);
    end

endmodule
